// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RISC-V load/store unit with alignment/range checks, load extension and read-modify-write sub-word stores.
module lsu_mem_port #(
  parameter int ADDR_TOP = 65535
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_fault,
  output logic [31:0]      mem_addr,
  input  logic [3:0][7:0]  mem_rdata,
  output logic [3:0][7:0]  mem_wdata,
  output logic             mem_we
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic we_r;
  logic [2:0] f3_r;
  logic [31:0] addr_r, wdata_r, ld;
  logic [3:0][7:0] buf_r, merged;
  logic legal, misal, oor, fault, sw;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    legal = req_we ? (req_funct3 < 3'd3) : (req_funct3 != 3'd3 && req_funct3[2:1] != 2'b11);
    misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
    oor = {1'b0, req_addr[31:2], 2'b00} + 33'd3 > 33'(ADDR_TOP);
    fault = !legal || misal || oor;
  end
  assign sw = we_r && f3_r[1:0] == 2'b10;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (fault ? RESP : ACCESS) : IDLE;
      ACCESS:  state_nx = (we_r && !sw) ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    b = mem_rdata[addr_r[1:0]];
    h = {mem_rdata[{addr_r[1], 1'b1}], mem_rdata[{addr_r[1], 1'b0}]};
    ld = f3_r[1:0] == 2'b00 ? {{24{~f3_r[2] & b[7]}}, b} :
         f3_r[1:0] == 2'b01 ? {{16{~f3_r[2] & h[15]}}, h} : mem_rdata;
  end
  // Sub-word merge: overwrite only the addressed lanes of the word read in ACCESS
  always_comb begin
    merged = buf_r;
    for (int i = 0; i < 4; i++) begin
      if (f3_r[1:0] == 2'b00 && 2'(i) == addr_r[1:0]) merged[i] = wdata_r[7:0];
      if (f3_r[1:0] == 2'b01 && 1'(i >> 1) == addr_r[1]) merged[i] = wdata_r[8*(i%2) +: 8];
    end
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_we = (state == ACCESS && sw) || state == WRITE;
  assign mem_addr = (state == ACCESS || state == WRITE) ? {addr_r[31:2], 2'b00} : '0;
  assign mem_wdata = state == WRITE ? merged : (state == ACCESS && sw) ? wdata_r : '0;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      we_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      buf_r <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_r <= req_we;
        f3_r <= req_funct3;
        addr_r <= req_addr;
        wdata_r <= req_wdata;
        resp_fault <= fault;
      end
      if (state == ACCESS) begin
        buf_r <= mem_rdata;
        if (!we_r) resp_rdata <= ld;
      end
      if (state == RESP) begin
        resp_rdata <= '0;
        resp_fault <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: scoreboard bench for lsu_mem_port against a byte-array reference model.
module tb_lsu_mem_port;
  logic clk = 1'b0, rst_b = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_fault, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  logic [3:0][7:0] mem_rdata, mem_wdata;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_TOP(65535)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  bit [7:0] mem [65536];
  bit [7:0] ref_mem [65536];

  always_comb begin
    for (int i = 0; i < 4; i++) mem_rdata[i] = mem[{mem_addr[15:2], 2'(i)}];
  end
  always @(posedge clk)
    if (mem_we) for (int i = 0; i < 4; i++) mem[{mem_addr[15:2], 2'(i)}] <= mem_wdata[i];

  typedef struct {
    logic [31:0] rdata;
    logic fault;
    int lat;
    int acc;
    logic [31:0] al;
    logic st;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, passes = 0;
  bit abort_test = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte-addressed memory, access size 1<<funct3[1:0], sign extension by arithmetic
  function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata);
    exp_t e;
    int size;
    longint al, v;
    bit legal;
    size = 1 << f3[1:0];
    al = longint'({addr[31:2], 2'b00});
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.al = 32'(al);
    e.st = 1'b0;
    e.rdata = '0;
    e.acc = 0;
    e.fault = !legal || (addr % size != 0) || (al + 3 > 65535);
    if (e.fault) e.lat = 1;
    else if (!we) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      e.rdata = v[31:0];
      e.lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      e.st = 1'b1;
      e.lat = size == 4 ? 2 : 3;
    end
    return e;
  endfunction

  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    exp_t e;
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    else begin
      e = model(we, f3, a, d);
      e.acc = cyc;
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  always @(negedge clk)
    if (rst_b) begin
      if (q.size() > 0 && cyc > q[0].acc) chk("req_ready_busy", req_ready, 0);
      if (mem_we && !abort_test) begin
        if (q.size() == 0 || !q[0].st) chk("mem_we_spurious", mem_we, 0);
        else chk("mem_addr", mem_addr, q[0].al);
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", resp_valid, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("fault", resp_fault, e.fault);
          chk("latency", cyc - e.acc, e.lat);
        end
      end else begin
        chk("idle_rdata", resp_rdata, 0);
        chk("idle_fault", resp_fault, 0);
        if (q.size() > 0 && cyc > q[0].acc + 5) begin
          chk("resp_timeout", resp_valid, 1);
          void'(q.pop_front());
        end
      end
    end

  initial begin
    bit [2:0] lf [5];
    bit we;
    bit [2:0] f3;
    bit [31:0] a;
    int n, diff;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_fault", resp_fault, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_b = 1'b1;
    @(negedge clk);
    abort_test = 1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd0;
    req_addr = 32'h122;
    req_wdata = 32'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_write", mem_we, 1);
    rst_b = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_b = 1'b1;
    abort_test = 0;
    repeat (3) @(negedge clk);
    chk("abort_mem", mem[16'h122], ref_mem[16'h122]);
    chk("abort_ready_after", req_ready, 1);
    issue(1, 3'd2, 32'h100, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h100, 0);
    issue(1, 3'd0, 32'h102, 32'h55);
    issue(0, 3'd2, 32'h100, 0);
    issue(0, 3'd0, 32'h102, 0);
    issue(0, 3'd1, 32'h102, 0);
    issue(0, 3'd5, 32'h102, 0);
    issue(0, 3'd4, 32'h103, 0);
    issue(0, 3'd2, 32'h101, 0);
    issue(1, 3'd1, 32'h103, 32'h1234);
    issue(0, 3'd1, 32'h001, 0);
    issue(0, 3'd2, 32'hFFFC, 0);
    issue(0, 3'd2, 32'h10000, 0);
    issue(1, 3'd4, 32'h100, 32'h77);
    issue(0, 3'd3, 32'h100, 0);
    for (int k = 0; k < 50; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      a = ($urandom_range(0, 9) == 0) ? 32'hFFF0 + $urandom_range(0, 15) : 32'h100 + $urandom_range(0, 63);
      a = a & ~((32'd1 << f3[1:0]) - 1);
      issue(we, f3, a, $urandom);
    end
    req_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    diff = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] != ref_mem[i]) diff++;
    chk("mem_image", diff, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the pipeline's memory stage and the word-addressable byte-array data memory.
- Accepts one RISC-V load/store per handshake and checks alignment and range.
- Loads: extracts the byte or halfword and sign/zero-extends it.
- Sub-word stores: the memory always writes 4 bytes, so SB/SH are done as read-modify-write (read aligned word, merge, write back).

Parameters:
- ADDR_TOP, 65535: highest valid byte address of the attached memory; an access is in range only if aligned_addr+3 <= ADDR_TOP.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (LSB-aligned).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  misaligned, out-of-range or illegal funct3; valid with resp_valid.
- mem_addr  out  32  byte address to memory; always 4-aligned.
- mem_rdata  in  4x8  memory read bytes; element 0 = byte at mem_addr (LSB). Combinational read.
- mem_wdata  out  4x8  write bytes; element 0 = LSB.
- mem_we  out  1  memory write enable; write occurs on the next clk edge.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0.
  - mem_we=0; mem_addr=0; mem_wdata all 0.
  - Reset mid-operation aborts the op: no write, no response.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1, mem_we=0.
  - On req_valid: latch req_we, req_funct3, req_addr, req_wdata.
  - Fault check. Fault if any of:
    - funct3 not legal for the direction;
    - H-type with addr[0]!=0;
    - W-type with addr[1:0]!=0;
    - {addr[31:2],2'b00}+3 > ADDR_TOP (compute in 33 bits, no wrap).
  - Fault -> RESP with resp_fault=1. No memory access ever occurs for a faulting request.
  - No fault -> ACCESS.
- ACCESS (one cycle):
  - mem_addr = {addr[31:2],2'b00}.
  - Load: capture the extracted result into resp_rdata -> RESP.
    - LB/LBU: byte k=addr[1:0].
    - LH/LHU: bytes 2*addr[1] and 2*addr[1]+1.
    - LW: {b3,b2,b1,b0}.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SW: mem_we=1, mem_wdata[i]=wdata[8i+7:8i] -> RESP.
  - SB/SH: capture mem_rdata into a merge buffer, mem_we=0 -> WRITE.
- WRITE (one cycle):
  - mem_addr held; mem_we=1; mem_wdata = merge buffer with replaced lanes:
    - SB: lane k <- wdata[7:0].
    - SH: lanes 2h, 2h+1 <- wdata[7:0], wdata[15:8], where h=addr[1].
  - Then -> RESP.
- RESP (one cycle):
  - resp_valid=1, req_ready=0, mem_we=0 -> IDLE.
  - resp_rdata and resp_fault are registered and stable during RESP. Outside RESP, resp_rdata and resp_fault are 0.
- Latency, from accept edge to resp_valid high:
  - fault: 1 cycle;
  - load and SW: 2 cycles;
  - SB/SH: 3 cycles.
- No response backpressure. Requests arriving while req_ready=0 are ignored; the requester holds them.
- Back-to-back: a new request may be accepted in the IDLE cycle directly after RESP.
- mem_we is only ever high in ACCESS (SW) or WRITE. mem_addr and mem_wdata are stable whenever mem_we=1.

Test Plan:
- Reset mid-SB: assert rst_b=0 while in WRITE -> mem_we drops immediately, memory is unchanged, no resp_valid, req_ready=1 after release.
- SW addr=0x100, wdata=0xDEADBEEF -> mem_we pulse with lanes EF,BE,AD,DE. Then LW 0x100 -> resp_rdata=0xDEADBEEF two cycles after accept, resp_fault=0.
- After the above, SB addr=0x102, wdata=0x55 -> word reads 0xDE55BEEF, latency 3. Then LB 0x102 -> 0x00000055; LH 0x102 -> 0xFFFFDE55; LHU 0x102 -> 0x0000DE55; LBU 0x103 -> 0x000000DE.
- Misalignment: LW 0x101, SH 0x103, LH 0x001 -> resp_fault=1, resp_rdata=0, latency 1, mem_we never asserted.
- Range and illegal funct3: with ADDR_TOP=65535, LW 0xFFFC OK; LW 0x10000 fault. Store with funct3=100 -> fault. Load with funct3=011 -> fault.
- Back-to-back traffic: 50 random legal load/stores vs. a byte-array model, requests held valid continuously -> exactly one resp_valid per accepted request, data matches the model, req_ready=0 from accept through RESP.
